load_unit: RTL and testbench
============================

# load_unit

Data-side load path of the 16-bit Harvard core: accepts one load request at a time from the execute stage, issues a read to data memory, waits a fixed memory latency, formats the returned word (word, or signed/unsigned byte) and presents it with its destination register to the write-back stage through a valid/ready handshake. It is the read counterpart of the write-back path, which drives data memory and the register file write port.

## Interface
- `DATA_W`, 16: data width; fixed at 16.
- `ADDR_W`, 16: byte address width.
- `REG_W`, 5: register destination index width.
- `MEM_LAT`, 2: data memory read latency in cycles, legal range 1..15.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: cancel any load in flight.
- `req_valid` in 1: load request present.
- `req_ready` out 1: unit can accept; `= (state==IDLE) && !flush`.
- `req_addr` in ADDR_W: byte address.
- `req_dest` in REG_W: destination register.
- `req_byte` in 1: 1 = byte load, 0 = word load.
- `req_signed` in 1: byte loads only; 1 = sign-extend, 0 = zero-extend.
- `mem_rd_en` out 1: one-cycle read strobe to data memory.
- `mem_rd_addr` out ADDR_W: word address `{1'b0, addr[15:1]}`.
- `mem_rd_data` in DATA_W: read data, valid MEM_LAT cycles after the `mem_rd_en` cycle.
- `wb_valid` out 1: formatted result available.
- `wb_ready` in 1: write-back accepts.
- `wb_data` out DATA_W: formatted load data.
- `wb_dest` out REG_W: destination register.
- `wb_err` out 1: misaligned word load (addr[0]=1); qualified by `wb_valid`.
- `wb_reg_write` out 1: register-file write enable `= wb_valid && wb_ready`.
- `busy` out 1: state != IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset -> IDLE.
- IDLE: on `req_valid && req_ready`, latch addr/dest/byte/signed; -> ISSUE.
- ISSUE (1 cycle): `mem_rd_en=1`, `mem_rd_addr` driven from latched addr; load counter with MEM_LAT-1; -> WAIT.
- WAIT: counter decrements each cycle; when counter==0, capture `mem_rd_data`, format, -> RESP.
- RESP: `wb_valid=1`; outputs held stable until `wb_ready`; on `wb_valid && wb_ready` -> IDLE.
- Formatting: word -> `mem_rd_data` unchanged, addr[0] ignored for data, `wb_err=addr[0]`. Byte -> byte = addr[0] ? data[15:8] : data[7:0]; upper 8 bits = signed ? replicate bit 7 : 0; `wb_err=0`.
- `flush` in ISSUE/WAIT/RESP: -> IDLE next cycle, pending data discarded, `wb_valid` low from next cycle; `mem_rd_en` still asserts if already in ISSUE (memory read harmless). `flush` in IDLE with `req_valid`: request not accepted.
- `flush` and `wb_ready` same cycle in RESP: handshake completes (`wb_reg_write=1` that cycle); then IDLE.
- No new request accepted outside IDLE; requests never queued.

## Timing
- Reset values: `mem_rd_en=0`, `mem_rd_addr=0`, `wb_valid=0`, `wb_data=0`, `wb_dest=0`, `wb_err=0`, `wb_reg_write=0`, `busy=0`; `req_ready=1` once `rst_n` high (if `flush` low).
- Accept at cycle T -> `mem_rd_en` high in T+1 -> data sampled at end of T+1+MEM_LAT -> `wb_valid` high from T+2+MEM_LAT.
- Minimum load-to-load interval: MEM_LAT+3 cycles (with `wb_ready` held high).
- `wb_*` outputs registered; `req_ready`, `wb_reg_write`, `busy` derived from state register (no input-to-output path except `flush`->`req_ready` and `wb_ready`->`wb_reg_write`).
- `rst_n` asserted mid-operation: immediate return to IDLE, all outputs to reset values asynchronously.

## Test plan
- MEM_LAT=2, word load addr 0x0040, dest 3, memory returns 0xBEEF: `mem_rd_en` at T+1 with `mem_rd_addr=0x0020`; `wb_valid` at T+4, `wb_data=0xBEEF`, `wb_dest=3`, `wb_err=0`.
- Byte loads on memory word 0x80_7F: addr 0x0041 signed -> 0xFF80; addr 0x0041 unsigned -> 0x0080; addr 0x0040 signed -> 0x007F.
- Word load addr 0x0041: `wb_err=1`, `wb_data` = full memory word.
- Back-pressure: `wb_ready` low 5 cycles in RESP -> `wb_valid`, `wb_data`, `wb_dest` stable, `req_ready=0`; `wb_reg_write` single pulse on release; next request accepted the cycle after.
- Flush in WAIT -> IDLE next cycle, no `wb_valid`, late `mem_rd_data` ignored; flush with `req_valid` in IDLE -> not accepted, no `mem_rd_en`.
- `rst_n` low during WAIT -> all outputs zero immediately; after release, fresh load completes normally with correct latency.

Source files
------------

// File: rtl/load_unit.sv
// load_unit: data-side load path. Accepts one load at a time, issues a word
// read to data memory, waits a fixed latency, formats the returned word as a
// word or a signed/unsigned byte, and hands it to write-back via valid/ready.
module load_unit #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int REG_W   = 5,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [REG_W-1:0]  req_dest,
  input  logic              req_byte,
  input  logic              req_signed,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_W-1:0]  wb_dest,
  output logic              wb_err,
  output logic              wb_reg_write,
  output logic              busy
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   lat_cnt;
  logic [ADDR_W-1:0]  addr_q;
  logic [REG_W-1:0]   dest_q;
  logic               byte_q;
  logic               signed_q;
  logic               accept;
  logic               capture;

  // Byte lanes: odd address selects the high byte; upper half is either the
  // replicated byte sign bit or zero. Word loads pass the memory word through.
  function automatic logic [DATA_W-1:0] format_load(
    input logic [DATA_W-1:0] word,
    input logic              hi,
    input logic              is_byte,
    input logic              is_signed
  );
    logic [7:0] b;
    b = hi ? word[15:8] : word[7:0];
    if (!is_byte) return word;
    return {{8{is_signed & b[7]}}, b};
  endfunction

  assign accept      = req_valid && req_ready;
  assign capture     = (state == WAIT) && (lat_cnt == '0) && !flush;
  assign mem_rd_addr = {1'b0, addr_q[ADDR_W-1:1]};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; flush abandons any load in flight.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = ISSUE;
      ISSUE: state_nxt = flush ? IDLE : WAIT;
      WAIT:  if (flush) state_nxt = IDLE;
             else if (lat_cnt == '0) state_nxt = RESP;
      RESP:  if (flush || wb_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs; only flush and wb_ready reach outputs combinationally.
  always_comb begin
    req_ready    = (state == IDLE) && !flush;
    mem_rd_en    = (state == ISSUE);
    wb_valid     = (state == RESP);
    busy         = (state != IDLE);
    wb_reg_write = (state == RESP) && wb_ready;
  end

  // Latency counter: loaded in ISSUE so it reaches zero in the data cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               lat_cnt <= '0;
    else if (state == ISSUE)                  lat_cnt <= CNT_W'(MEM_LAT - 1);
    else if (state == WAIT && lat_cnt != '0)  lat_cnt <= lat_cnt - 1'b1;
  end

  // Request latch; held for the whole load so the read address stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      dest_q   <= '0;
      byte_q   <= 1'b0;
      signed_q <= 1'b0;
    end else if (accept) begin
      addr_q   <= req_addr;
      dest_q   <= req_dest;
      byte_q   <= req_byte;
      signed_q <= req_signed;
    end
  end

  // Result registers: captured once when the memory word arrives, then held
  // unchanged through any write-back stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_data <= '0;
      wb_dest <= '0;
      wb_err  <= 1'b0;
    end else if (capture) begin
      wb_data <= format_load(mem_rd_data, addr_q[0], byte_q, signed_q);
      wb_dest <= dest_q;
      wb_err  <= !byte_q && addr_q[0];
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// Bench for load_unit: directed and random loads against a behavioural
// memory and an arithmetic formatting model.
module tb_load_unit;

  localparam int MEM_LAT = 2;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic [4:0]  req_dest;
  logic        req_byte;
  logic        req_signed;
  logic        mem_rd_en;
  logic [15:0] mem_rd_addr;
  logic [15:0] mem_rd_data;
  logic        wb_valid;
  logic        wb_ready;
  logic [15:0] wb_data;
  logic [4:0]  wb_dest;
  logic        wb_err;
  logic        wb_reg_write;
  logic        busy;

  load_unit #(.DATA_W(16), .ADDR_W(16), .REG_W(5), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_dest(req_dest), .req_byte(req_byte), .req_signed(req_signed),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_dest(wb_dest), .wb_err(wb_err), .wb_reg_write(wb_reg_write),
    .busy(busy)
  );

  int passes = 0;
  int total  = 0;
  int fails  = 0;

  logic [15:0] mem [256];
  logic [15:0] exp_data;
  logic [4:0]  exp_dest;
  logic        exp_err;

  // Memory: the word read at a strobe appears exactly MEM_LAT cycles later;
  // every other cycle carries random junk.
  int          rem = 0;
  bit          pending = 0;
  logic [7:0]  raddr;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    mem_rd_data = 16'($urandom);
    if (!rst_n) pending = 0;
    if (pending) begin
      rem--;
      if (rem == 0) begin
        mem_rd_data = mem[raddr];
        pending = 0;
      end
    end
    if (mem_rd_en) begin
      pending = 1;
      rem = MEM_LAT;
      raddr = mem_rd_addr[7:0];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] ref_load(input logic [15:0] word, input int a,
                                           input bit b, input bit s);
    int v;
    if (!b) return word;
    v = (a % 2 == 1) ? int'(word) / 256 : int'(word) % 256;
    if (s && v >= 128) v = v + 65280;
    return 16'(v);
  endfunction

  // Accept a load and advance to the first response cycle, checking timing.
  task automatic start_to_resp(input logic [15:0] a, input logic [4:0] d,
                               input bit b, input bit s);
    int n = 0;
    while (!req_ready && n < 20) begin step(); n++; end
    chk("req_ready_idle", 32'(req_ready), 1);
    req_valid = 1; req_addr = a; req_dest = d; req_byte = b; req_signed = s;
    wb_ready = 0;
    exp_data = ref_load(mem[int'(a) / 2 % 256], int'(a), b, s);
    exp_dest = d;
    exp_err  = !b && (a % 2 == 1);
    step();
    req_valid = 0; req_addr = 16'($urandom); req_dest = 5'($urandom);
    req_byte = 1'($urandom); req_signed = 1'($urandom);
    chk("rd_en_issue", 32'(mem_rd_en), 1);
    chk("rd_addr", 32'(mem_rd_addr), 32'(int'(a) / 2));
    chk("busy_issue", 32'(busy), 1);
    chk("req_ready_busy", 32'(req_ready), 0);
    for (int i = 0; i < MEM_LAT; i++) begin
      step();
      chk("wait_no_valid", 32'(wb_valid), 0);
      chk("rd_en_single", 32'(mem_rd_en), 0);
    end
    step();
    chk("wb_valid", 32'(wb_valid), 1);
    chk("wb_data", 32'(wb_data), 32'(exp_data));
    chk("wb_dest", 32'(wb_dest), 32'(exp_dest));
    chk("wb_err", 32'(wb_err), 32'(exp_err));
  endtask

  // Hold wb_ready low for 'hold' cycles, then complete the handshake.
  task automatic finish_resp(input int hold);
    for (int i = 0; i < hold; i++) begin
      chk("stall_no_write", 32'(wb_reg_write), 0);
      chk("stall_req_ready", 32'(req_ready), 0);
      step();
      chk("stall_valid", 32'(wb_valid), 1);
      chk("stall_data", 32'(wb_data), 32'(exp_data));
      chk("stall_dest", 32'(wb_dest), 32'(exp_dest));
    end
    wb_ready = 1;
    #1;
    chk("reg_write_pulse", 32'(wb_reg_write), 1);
    step();
    chk("valid_drop", 32'(wb_valid), 0);
    chk("reg_write_end", 32'(wb_reg_write), 0);
    chk("req_ready_after", 32'(req_ready), 1);
  endtask

  initial begin
    rst_n = 1; flush = 0; req_valid = 0; req_addr = 0; req_dest = 0;
    req_byte = 0; req_signed = 0; wb_ready = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    #1 rst_n = 0;
    #1;
    chk("rst_rd_en", 32'(mem_rd_en), 0);
    chk("rst_rd_addr", 32'(mem_rd_addr), 0);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_wb_data", 32'(wb_data), 0);
    chk("rst_wb_dest", 32'(wb_dest), 0);
    chk("rst_wb_err", 32'(wb_err), 0);
    chk("rst_reg_write", 32'(wb_reg_write), 0);
    chk("rst_busy", 32'(busy), 0);
    step(); step();
    rst_n = 1;
    step();
    chk("rst_req_ready", 32'(req_ready), 1);

    // Word load, aligned.
    mem[8'h20] = 16'hBEEF;
    start_to_resp(16'h0040, 5'd3, 0, 0);
    chk("beef_data", 32'(wb_data), 32'hBEEF);
    finish_resp(0);

    // Byte loads on 0x807F.
    mem[8'h20] = 16'h807F;
    start_to_resp(16'h0041, 5'd4, 1, 1);
    chk("byte_hi_signed", 32'(wb_data), 32'hFF80);
    finish_resp(0);
    start_to_resp(16'h0041, 5'd5, 1, 0);
    chk("byte_hi_unsigned", 32'(wb_data), 32'h0080);
    finish_resp(0);
    start_to_resp(16'h0040, 5'd6, 1, 1);
    chk("byte_lo_signed", 32'(wb_data), 32'h007F);
    finish_resp(0);

    // Misaligned word load.
    start_to_resp(16'h0041, 5'd7, 0, 0);
    chk("misaligned_err", 32'(wb_err), 1);
    chk("misaligned_data", 32'(wb_data), 32'h807F);
    finish_resp(0);

    // Back-pressure for 5 cycles.
    start_to_resp(16'h0102, 5'd9, 0, 0);
    finish_resp(5);

    // Flush while waiting on memory.
    start_to_resp(16'h0010, 5'd1, 0, 0);
    finish_resp(0);
    req_valid = 1; req_addr = 16'h0050; req_dest = 5'd2; req_byte = 0;
    step();
    req_valid = 0;
    step();
    flush = 1;
    #1;
    chk("flush_req_ready", 32'(req_ready), 0);
    step();
    flush = 0;
    chk("flush_idle", 32'(busy), 0);
    for (int i = 0; i < 3; i++) begin
      chk("flush_no_valid", 32'(wb_valid), 0);
      step();
    end

    // Flush in IDLE blocks acceptance.
    req_valid = 1; flush = 1;
    #1;
    chk("flush_idle_ready", 32'(req_ready), 0);
    step();
    req_valid = 0; flush = 0;
    chk("flush_idle_no_rd", 32'(mem_rd_en), 0);
    chk("flush_idle_busy", 32'(busy), 0);

    // Flush together with wb_ready in RESP still completes the write.
    start_to_resp(16'h0033, 5'd12, 1, 0);
    flush = 1; wb_ready = 1;
    #1;
    chk("flush_resp_write", 32'(wb_reg_write), 1);
    step();
    flush = 0;
    chk("flush_resp_idle", 32'(busy), 0);
    chk("flush_resp_novalid", 32'(wb_valid), 0);

    // Asynchronous reset mid-load.
    mem[8'h30] = 16'h1234;
    start_to_resp(16'h0060, 5'd8, 0, 0);
    finish_resp(0);
    req_valid = 1; req_addr = 16'h0062; req_dest = 5'd10; req_byte = 0;
    step();
    req_valid = 0;
    step();
    #2 rst_n = 0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_data", 32'(wb_data), 0);
    chk("mid_rst_dest", 32'(wb_dest), 0);
    chk("mid_rst_rd_addr", 32'(mem_rd_addr), 0);
    chk("mid_rst_rd_en", 32'(mem_rd_en), 0);
    chk("mid_rst_valid", 32'(wb_valid), 0);
    step();
    rst_n = 1;
    step();
    start_to_resp(16'h0060, 5'd11, 1, 0);
    chk("post_rst_data", 32'(wb_data), 32'h0034);
    finish_resp(0);

    // Random loads.
    for (int k = 0; k < 25; k++) begin
      logic [15:0] a;
      a = 16'($urandom_range(0, 511));
      start_to_resp(a, 5'($urandom), 1'($urandom), 1'($urandom));
      finish_resp(int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
